// File: rtl/prbs_lfsr_checker.sv
// Serial PRBS checker for the prng_lfsr XNOR stream (MSB-first): self-seeds, then predicts and compares.
// Define PRBS_CHK_AUTO_RESYNC_EN to build window loss-of-lock detection with automatic reseed.
module prbs_lfsr_checker #(
  parameter int unsigned MAXSYMBOLWIDTH = 128
`ifdef PRBS_CHK_AUTO_RESYNC_EN
  ,
  parameter int unsigned LOSS_THRESH = 8
`endif
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            load_mode,
  input  logic [$clog2(MAXSYMBOLWIDTH):0] mode,
  input  logic                            clear_counts,
  input  logic                            valid_in,
  input  logic                            lfsr_in,
  output logic                            locked,
  output logic                            error_pulse,
  output logic                            lock_lost,
  output logic [31:0]                     bit_count,
  output logic [31:0]                     error_count
);
  localparam int unsigned MODE_W = $clog2(MAXSYMBOLWIDTH) + 1;
  localparam int unsigned CNT_W  = 32;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
  localparam int unsigned WIN_W  = 6;
  localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);
`endif

  typedef enum logic {SEED, CHECK} state_t;

  state_t                    state_q, state_d;
  logic [MAXSYMBOLWIDTH-1:0] ref_q, ref_d;
  logic [MODE_W-1:0]         width_q, width_d;
  logic [MODE_W-1:0]         seed_cnt_q, seed_cnt_d;
  logic [CNT_W-1:0]          bit_count_d, error_count_d;
  logic                      locked_d, error_pulse_d;
  logic                      predict, mismatch;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
  logic [WIN_W-1:0]          win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]         win_err_q, win_err_d;
  logic                      lock_lost_d;
`endif

  // Unsupported widths fall back to 32.
  function automatic logic [MODE_W-1:0] sanitize(input logic [MODE_W-1:0] m);
    case (m)
      MODE_W'(8), MODE_W'(16), MODE_W'(20), MODE_W'(32), MODE_W'(40),
      MODE_W'(52), MODE_W'(64), MODE_W'(80), MODE_W'(96), MODE_W'(128): return m;
      default: return MODE_W'(32);
    endcase
  endfunction

  function automatic logic [MAXSYMBOLWIDTH-1:0] tap_mask(input logic [MODE_W-1:0] w);
    logic [MAXSYMBOLWIDTH-1:0] m;
    m = '0;
    case (w)
      MODE_W'(8):   {m[7], m[5], m[4], m[3]}         = 4'hF;
      MODE_W'(16):  {m[15], m[14], m[12], m[3]}      = 4'hF;
      MODE_W'(20):  {m[19], m[16]}                   = 2'b11;
      MODE_W'(40):  {m[39], m[37], m[20], m[18]}     = 4'hF;
      MODE_W'(52):  {m[51], m[48]}                   = 2'b11;
      MODE_W'(64):  {m[63], m[62], m[60], m[59]}     = 4'hF;
      MODE_W'(80):  {m[79], m[78], m[42], m[41]}     = 4'hF;
      MODE_W'(96):  {m[95], m[93], m[48], m[46]}     = 4'hF;
      MODE_W'(128): {m[127], m[125], m[100], m[98]}  = 4'hF;
      default:      {m[31], m[21], m[1], m[0]}       = 4'hF;
    endcase
    return m;
  endfunction

  // Next-state, reference shift, counters and window.
  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    width_d       = width_q;
    seed_cnt_d    = seed_cnt_q;
    bit_count_d   = bit_count;
    error_count_d = error_count;
    error_pulse_d = 1'b0;
    mismatch      = 1'b0;
    predict       = ~^(ref_q & tap_mask(width_q));
`ifdef PRBS_CHK_AUTO_RESYNC_EN
    win_cnt_d     = win_cnt_q;
    win_err_d     = win_err_q;
    lock_lost_d   = 1'b0;
`endif

    if (load_mode) begin
      width_d       = sanitize(mode);
      state_d       = SEED;
      seed_cnt_d    = '0;
      bit_count_d   = '0;
      error_count_d = '0;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
      win_cnt_d     = '0;
      win_err_d     = '0;
`endif
    end else begin
      if (valid_in) begin
        case (state_q)
          SEED: begin
            ref_d      = {ref_q[MAXSYMBOLWIDTH-2:0], lfsr_in};
            seed_cnt_d = seed_cnt_q + MODE_W'(1);
            if (seed_cnt_q == width_q - MODE_W'(1)) state_d = CHECK;
          end
          CHECK: begin
            // Shift the prediction so one flipped bit costs exactly one error.
            mismatch      = predict ^ lfsr_in;
            ref_d         = {ref_q[MAXSYMBOLWIDTH-2:0], predict};
            error_pulse_d = mismatch;
            if (~&bit_count) bit_count_d = bit_count + CNT_W'(1);
            if (mismatch && ~&error_count) error_count_d = error_count + CNT_W'(1);
`ifdef PRBS_CHK_AUTO_RESYNC_EN
            if (mismatch && (win_err_q == WERR_W'(LOSS_THRESH - 1))) begin
              lock_lost_d = 1'b1;
              state_d     = SEED;
              seed_cnt_d  = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else if (win_cnt_q == WIN_W'(63)) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WIN_W'(1);
              win_err_d = win_err_q + WERR_W'(mismatch);
            end
`endif
          end
          default: state_d = SEED;
        endcase
      end
      if (clear_counts) begin
        bit_count_d   = '0;
        error_count_d = '0;
      end
    end
    locked_d = (state_d == CHECK);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= SEED;
      ref_q       <= '0;
      width_q     <= MODE_W'(32);
      seed_cnt_q  <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      bit_count   <= '0;
      error_count <= '0;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      lock_lost   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      width_q     <= width_d;
      seed_cnt_q  <= seed_cnt_d;
      locked      <= locked_d;
      error_pulse <= error_pulse_d;
      bit_count   <= bit_count_d;
      error_count <= error_count_d;
`ifdef PRBS_CHK_AUTO_RESYNC_EN
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      lock_lost   <= lock_lost_d;
`endif
    end
  end

`ifndef PRBS_CHK_AUTO_RESYNC_EN
  assign lock_lost = 1'b0;
`endif

endmodule
